// File: rtl/fifo_wr_ingress_if.sv
// Write-side bus of the async FIFO ingress: producer stream, FIFO write port,
// pointer inputs and fill-level outputs.
interface fifo_wr_ingress_if #(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ADDRSIZE = 6
);
    logic                s_valid;
    logic [DSIZE-1:0]    s_data;
    logic                s_ready;
    logic                wfull;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                winc;
    logic [DSIZE-1:0]    wdata;
    logic [ADDRSIZE:0]   wcount;
    logic                walmost_full;

    // Environment side: producer plus write-pointer/full logic
    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wcount, walmost_full
    );

    // Ingress side
    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wcount, walmost_full
    );
endinterface

// File: rtl/fifo_wr_ingress.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer feeding the
// FIFO write port, plus registered fill level and almost-full flag.
module fifo_wr_ingress #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ADDRSIZE  = 6,
    parameter int unsigned AF_MARGIN = 4
) (
    input  logic               wclk,
    input  logic               wrst_n,
    fifo_wr_ingress_if.slave   bus
);
    localparam int unsigned CNT_W    = ADDRSIZE + 1;
    localparam int unsigned DEPTH    = 1 << ADDRSIZE;
    localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t             state, state_n;
    logic [DSIZE-1:0]   head, head_n;
    logic [DSIZE-1:0]   tail, tail_n;
    logic               s_ready_q, s_ready_n;
    logic [CNT_W-1:0]   wcount_q, wcount_n;
    logic               af_q;
    logic               accept, pop;

    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b = g;
        for (int unsigned i = 1; i < CNT_W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    // Write request depends only on buffer occupancy and wfull
    assign pop    = (state != S_EMPTY) & ~bus.wfull;
    assign accept = bus.s_valid & s_ready_q;

    // Skid buffer next state
    always_comb begin
        state_n = state;
        head_n  = head;
        tail_n  = tail;
        unique case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_n = S_ONE;
                    head_n  = bus.s_data;
                end
            end
            S_ONE: begin
                if (accept && !pop) begin
                    state_n = S_TWO;
                    tail_n  = bus.s_data;
                end else if (accept && pop) begin
                    head_n  = bus.s_data;
                end else if (pop) begin
                    state_n = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    state_n = S_ONE;
                    head_n  = tail;
                end
            end
            default: state_n = S_EMPTY;
        endcase
        s_ready_n = (state_n != S_TWO);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= S_EMPTY;
            head      <= '0;
            tail      <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state     <= state_n;
            head      <= head_n;
            tail      <= tail_n;
            s_ready_q <= s_ready_n;
        end
    end

    // Modular pointer difference absorbs wrap; lagging read pointer overstates fill
    assign wcount_n = gray2bin(bus.wptr) - gray2bin(bus.wq2_rptr);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wcount_q <= '0;
            af_q     <= 1'b0;
        end else begin
            wcount_q <= wcount_n;
            af_q     <= (wcount_n >= CNT_W'(AF_LEVEL));
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.winc         = pop;
    assign bus.wdata        = head;
    assign bus.wcount       = wcount_q;
    assign bus.walmost_full = af_q;
endmodule
